// File: rtl/lemming_world.sv
// Purpose : 1-D terrain environment for a lemming walker; turns walker status into bump/ground feedback.
// Latency : bump_left/bump_right/ground are combinational (0 cycles); pos/proto_err/counters update 1 cycle after inputs.
// Backpressure: none; every cycle's inputs are consumed, and illegal status patterns only raise the sticky proto_err.
//
// Ports:
//   sys_clk, sys_rst              clock, synchronous active-high reset
//   walk_left, walk_right, aaah   walker status (exactly one expected high each cycle)
//   bump_left, bump_right         wall or terrain edge adjacent in the walking direction
//   ground                        floor present under the current cell
//   pos                           current cell index
//   proto_err                     sticky walker protocol violation
//   step_cnt, fall_cnt            saturating move/fall statistics
// Build option: define LEMMING_WORLD_STATS_EN to build the statistics counters;
// otherwise step_cnt/fall_cnt are tied to zero.
module lemming_world #(
  parameter int               WIDTH     = 16,
  parameter int               POS_W     = 4,
  parameter logic [WIDTH-1:0] WALLS     = '0,
  parameter logic [WIDTH-1:0] HOLES     = '0,
  parameter int               DEPTH     = 3,
  parameter int               START_POS = 0
) (
  input  logic             sys_clk,
  input  logic             sys_rst,
  input  logic             walk_left,
  input  logic             walk_right,
  input  logic             aaah,
  output logic             bump_left,
  output logic             bump_right,
  output logic             ground,
  output logic [POS_W-1:0] pos,
  output logic             proto_err,
  output logic [15:0]      step_cnt,
  output logic [7:0]       fall_cnt
);

  localparam int               FD_W      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [FD_W-1:0]  FD_LAST   = FD_W'(DEPTH - 1);
  localparam logic [POS_W-1:0] POS_START = POS_W'(START_POS);
  // Terrain edges behave as walls: bit i is the wall left of cell i, bit i+2 the wall right of it.
  localparam logic [WIDTH+1:0] WALL_PAD  = {1'b1, WALLS, 1'b1};

  logic [POS_W-1:0] pos_q, pos_d;
  logic [WIDTH-1:0] hole_q, hole_d;
  logic [FD_W-1:0]  fdepth_q, fdepth_d;
  logic             aaah_g_q, aaah_g_d;
  logic             walk_ng_q, walk_ng_d;
  logic             proto_err_q, proto_err_d;

  logic hole_here, wall_l, wall_r, walking, one_hot;

  // Cell lookups by comparison so the index never depends on 2**POS_W matching WIDTH.
  always_comb begin
    hole_here = 1'b0;
    wall_l    = 1'b0;
    wall_r    = 1'b0;
    for (int i = 0; i < WIDTH; i++) begin
      if (pos_q == POS_W'(i)) begin
        hole_here = hole_q[i];
        wall_l    = WALL_PAD[i];
        wall_r    = WALL_PAD[i+2];
      end
    end
  end

  assign walking    = walk_left | walk_right;
  // Exactly one of three: odd parity, but not all three.
  assign one_hot    = (walk_left ^ walk_right ^ aaah) & ~(walk_left & walk_right & aaah);
  assign ground     = ~hole_here;
  assign bump_left  = walk_left & wall_l;
  assign bump_right = walk_right & wall_r;
  assign pos        = pos_q;
  assign proto_err  = proto_err_q;

  always_comb begin
    pos_d    = pos_q;
    hole_d   = hole_q;
    fdepth_d = fdepth_q;
    if (!ground) begin
      // Falling: position is frozen; the last fall cycle fills the hole for good.
      if (fdepth_q == FD_LAST) begin
        fdepth_d = '0;
        hole_d   = hole_q & ~(WIDTH'(1) << pos_q);
      end else begin
        fdepth_d = fdepth_q + FD_W'(1);
      end
    end else if (one_hot) begin
      if (walk_left && !wall_l) begin
        pos_d = pos_q - POS_W'(1);
      end else if (walk_right && !wall_r) begin
        pos_d = pos_q + POS_W'(1);
      end
    end

    // Remember "bad-looking" cycles; the error fires only on a second consecutive one.
    aaah_g_d    = aaah & ground;
    walk_ng_d   = walking & ~ground;
    proto_err_d = proto_err_q | ~one_hot
                | (aaah_g_q & aaah & ground)
                | (walk_ng_q & walking & ~ground);
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      pos_q       <= POS_START;
      hole_q      <= HOLES;
      fdepth_q    <= '0;
      aaah_g_q    <= 1'b0;
      walk_ng_q   <= 1'b0;
      proto_err_q <= 1'b0;
    end else begin
      pos_q       <= pos_d;
      hole_q      <= hole_d;
      fdepth_q    <= fdepth_d;
      aaah_g_q    <= aaah_g_d;
      walk_ng_q   <= walk_ng_d;
      proto_err_q <= proto_err_d;
    end
  end

`ifdef LEMMING_WORLD_STATS_EN
  logic [15:0] step_cnt_q, step_cnt_d;
  logic [7:0]  fall_cnt_q, fall_cnt_d;
  logic        moved, landed;

  always_comb begin
    moved      = ground & one_hot & ((walk_left & ~wall_l) | (walk_right & ~wall_r));
    landed     = ~ground & (fdepth_q == FD_LAST);
    step_cnt_d = step_cnt_q;
    fall_cnt_d = fall_cnt_q;
    if (moved && step_cnt_q != 16'hFFFF) step_cnt_d = step_cnt_q + 16'd1;
    if (landed && fall_cnt_q != 8'hFF)   fall_cnt_d = fall_cnt_q + 8'd1;
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      step_cnt_q <= '0;
      fall_cnt_q <= '0;
    end else begin
      step_cnt_q <= step_cnt_d;
      fall_cnt_q <= fall_cnt_d;
    end
  end

  assign step_cnt = step_cnt_q;
  assign fall_cnt = fall_cnt_q;
`else
  assign step_cnt = '0;
  assign fall_cnt = '0;
`endif

endmodule

// File: tb/tb_lemming_world.sv
// Purpose : closed-loop stimulus for lemming_world on an 8-cell terrain (wall at 5, hole at 2, start 3).
// Latency : combinational outputs checked before each edge, registered outputs 1 ns after it.
// Backpressure: not applicable; one stimulus vector per clock.
module tb_lemming_world;

  logic       sys_clk = 1'b0;
  logic       sys_rst;
  logic       walk_left, walk_right, aaah;
  logic       bump_left, bump_right, ground, proto_err;
  logic [2:0] pos;
  logic [15:0] step_cnt;
  logic [7:0]  fall_cnt;

  always #5 sys_clk = ~sys_clk;

`ifdef LEMMING_WORLD_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  lemming_world #(
    .WIDTH(8), .POS_W(3), .WALLS(8'b0010_0000), .HOLES(8'b0000_0100),
    .DEPTH(3), .START_POS(3)
  ) dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst),
    .walk_left(walk_left), .walk_right(walk_right), .aaah(aaah),
    .bump_left(bump_left), .bump_right(bump_right), .ground(ground),
    .pos(pos), .proto_err(proto_err), .step_cnt(step_cnt), .fall_cnt(fall_cnt)
  );

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    string tag;
    int    pos;
    bit    err;
    int    st;
    int    fl;
  } exp_t;

  exp_t sb[$];

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Counter expectations collapse to zero when statistics are not built.
  function automatic int sc(input int n);
    return STATS ? n : 0;
  endfunction

  // One clock of stimulus: zero-latency outputs checked before the edge,
  // post-edge state expectation queued and compared after the edge.
  task automatic step(input string tag, input bit wl, input bit wr, input bit aa,
                      input bit ebl, input bit ebr, input bit egnd,
                      input int epos, input bit eerr, input int est, input int efl);
    exp_t e;
    @(negedge sys_clk);
    walk_left  = wl;
    walk_right = wr;
    aaah       = aa;
    #1;
    check_eq({tag, ".bump_l"}, 32'(bump_left), 32'(ebl));
    check_eq({tag, ".bump_r"}, 32'(bump_right), 32'(ebr));
    check_eq({tag, ".ground"}, 32'(ground), 32'(egnd));
    e.tag = tag; e.pos = epos; e.err = eerr; e.st = est; e.fl = efl;
    sb.push_back(e);
    @(posedge sys_clk);
    #1;
    if (sb.size() == 0) begin
      check_eq({tag, ".sb_empty"}, 32'd1, 32'd0);
    end else begin
      e = sb.pop_front();
      check_eq({e.tag, ".pos"},  32'(pos), 32'(e.pos));
      check_eq({e.tag, ".err"},  32'(proto_err), 32'(e.err));
      check_eq({e.tag, ".step"}, 32'(step_cnt), 32'(e.st));
      check_eq({e.tag, ".fall"}, 32'(fall_cnt), 32'(e.fl));
    end
  endtask

  task automatic do_reset(input bit wl, input bit wr, input bit aa);
    @(negedge sys_clk);
    sys_rst    = 1'b1;
    walk_left  = wl;
    walk_right = wr;
    aaah       = aa;
    @(posedge sys_clk);
    #1;
    sys_rst = 1'b0;
  endtask

  task automatic check_reset(input string tag);
    check_eq({tag, ".pos"},    32'(pos), 32'd3);
    check_eq({tag, ".err"},    32'(proto_err), 32'd0);
    check_eq({tag, ".step"},   32'(step_cnt), 32'd0);
    check_eq({tag, ".fall"},   32'(fall_cnt), 32'd0);
    check_eq({tag, ".ground"}, 32'(ground), 32'd1);
  endtask

  initial begin
    sys_rst    = 1'b1;
    walk_left  = 1'b0;
    walk_right = 1'b0;
    aaah       = 1'b0;
    do_reset(0, 1, 0);
    do_reset(0, 1, 0);
    check_reset("rst0");

    // Walk right into the wall at cell 5.
    step("r1",  0, 1, 0, 0, 0, 1, 4, 0, sc(1), sc(0));
    step("r2",  0, 1, 0, 0, 1, 1, 4, 0, sc(1), sc(0));
    step("r3",  0, 1, 0, 0, 1, 1, 4, 0, sc(1), sc(0));
    // Walk left onto the hole at cell 2 and fall for DEPTH cycles.
    step("l1",  1, 0, 0, 0, 0, 1, 3, 0, sc(2), sc(0));
    step("l2",  1, 0, 0, 0, 0, 1, 2, 0, sc(3), sc(0));
    step("f1",  0, 0, 1, 0, 0, 0, 2, 0, sc(3), sc(0));
    step("f2",  0, 0, 1, 0, 0, 0, 2, 0, sc(3), sc(0));
    step("f3",  0, 0, 1, 0, 0, 0, 2, 0, sc(3), sc(1));
    // Hole filled; continue to the left edge.
    step("l3",  1, 0, 0, 0, 0, 1, 1, 0, sc(4), sc(1));
    step("l4",  1, 0, 0, 0, 0, 1, 0, 0, sc(5), sc(1));
    step("l5",  1, 0, 0, 1, 0, 1, 0, 0, sc(5), sc(1));
    // Back right across the filled cell.
    step("r4",  0, 1, 0, 0, 0, 1, 1, 0, sc(6), sc(1));
    step("r5",  0, 1, 0, 0, 0, 1, 2, 0, sc(7), sc(1));
    step("r6",  0, 1, 0, 0, 0, 1, 3, 0, sc(8), sc(1));
    // Two walk directions at once: no move, sticky error.
    step("both", 1, 1, 0, 0, 0, 1, 3, 1, sc(8), sc(1));
    for (int i = 0; i < 10; i++) begin
      if (i % 2 == 0) step("legal", 0, 1, 0, 0, 0, 1, 4, 1, sc(9 + i), sc(1));
      else            step("legal", 1, 0, 0, 0, 0, 1, 3, 1, sc(9 + i), sc(1));
    end
    do_reset(0, 0, 0);
    check_reset("rst1");

    // aaah with ground on two consecutive cycles.
    step("aa1", 0, 0, 1, 0, 0, 1, 3, 0, 0, 0);
    step("aa2", 0, 0, 1, 0, 0, 1, 3, 1, 0, 0);
    do_reset(0, 0, 0);
    check_reset("rst2");

    // Reset in the middle of a fall restores the hole map.
    step("mf_l",  1, 0, 0, 0, 0, 1, 2, 0, sc(1), sc(0));
    step("mf_a",  0, 0, 1, 0, 0, 0, 2, 0, sc(1), sc(0));
    do_reset(0, 0, 1);
    check_reset("rst_mf");

    // Hole at 2 is back; walking while falling twice is an error.
    step("h_l",   1, 0, 0, 0, 0, 1, 2, 0, sc(1), sc(0));
    step("h_w1",  1, 0, 0, 0, 0, 0, 2, 0, sc(1), sc(0));
    step("h_w2",  1, 0, 0, 0, 0, 0, 2, 1, sc(1), sc(0));
    step("h_a",   0, 0, 1, 0, 0, 0, 2, 1, sc(1), sc(1));
    step("h_r",   0, 1, 0, 0, 0, 1, 3, 1, sc(2), sc(1));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
